brew_sequencer: RTL and testbench
=================================

Name: brew_sequencer

Overview:
Top-level brew controller for the coffee maker. On a start request it latches the selected coffee type. It then walks ingredients 0..4 in order, querying the time-selector block for each ingredient's dispense time in units, and opens the matching ingredient valve for t_value × UNIT_TICKS clock cycles. It sits between the user-panel logic (start/cancel/type) and the valve drivers, and owns the select inputs of the time-selector.

Parameters:
UNIT_TICKS, 50000000, clock cycles per dispense time unit (1 s at 50 MHz); the bench uses 4
NUM_ING, 5, number of ingredients sequenced (indices 0..NUM_ING-1)
CNT_W, 32, width of the dispense tick counter; must hold 3×UNIT_TICKS

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  request to brew; sampled only in IDLE
cancel  in  1  abort current brew; level, sampled every cycle
c_type  in  3  coffee type; valid values 1..4
t_value  in  2  dispense units from the time-selector; registered there, valid 1 cycle after selects change
sel_c_type  out  3  coffee type driven to the time-selector
sel_ing_type  out  3  ingredient index driven to the time-selector
valve  out  5  one-hot valve enables, bit i = ingredient i
busy  out  1  high from start acceptance until return to IDLE
done  out  1  1-cycle pulse on normal completion
aborted  out  1  1-cycle pulse on cancel-terminated brew
error  out  1  1-cycle pulse when start is rejected for invalid c_type

Behaviour:
- Reset (async, immediate): state=IDLE; sel_c_type=0; sel_ing_type=0; valve=0; busy=0; done=0; aborted=0; error=0; counter=0. Reset mid-brew closes all valves immediately.
- All outputs are registered.
- States: IDLE, QUERY, LOAD, DISPENSE, NEXT, FINISH.
- IDLE:
  - start=1, cancel=0, c_type in 1..4 -> latch c_type into sel_c_type, sel_ing_type=0, busy=1, go to QUERY.
  - start=1, c_type 0 or 5..7 -> error pulse next cycle, stay IDLE.
  - start=1 with cancel=1 -> ignored, no pulses.
- QUERY: one cycle; the time-selector samples the selects at its end.
- LOAD: sample t_value.
  - t_value=0 -> NEXT; valve stays 0.
  - Otherwise load counter = t_value×UNIT_TICKS − 1, assert valve[sel_ing_type], go to DISPENSE.
- DISPENSE: valve held; counter decrements each cycle. At counter==0, valve=0 on the next edge and go to NEXT. Valve-high time is exactly t_value×UNIT_TICKS cycles.
- NEXT: one cycle.
  - sel_ing_type==NUM_ING−1 -> FINISH.
  - Otherwise increment sel_ing_type and go to QUERY.
  - sel_ing_type never wraps during a brew.
- FINISH: one cycle; done=1 for this cycle only. Then IDLE with busy=0, sel_ing_type=0; sel_c_type holds its last value.
- Per-ingredient overhead: QUERY+LOAD+NEXT = 3 cycles, plus dispense cycles.
- Cancel:
  - cancel=1 in any state other than IDLE/FINISH -> next edge: valve=0, counter=0, aborted=1 for one cycle, busy=0, state=IDLE.
  - Cancel has priority over counter expiry in the same cycle.
  - cancel in FINISH is ignored; done still pulses.
- start while busy is ignored; c_type changes during a brew are ignored, since the value was latched at start.
- At most one valve bit is high in any cycle. done, aborted and error are mutually exclusive.
- t_value is only sampled in LOAD; its value in other states is don't-care.

Test Plan:
- UNIT_TICKS=4, c_type=1, time-selector returns {2,3,0,0,1} -> valve[0] high 8 cycles, valve[1] 12, valve[2]/[3] never, valve[4] 4; done pulses once; busy low the cycle after done; total busy = 15 overhead + 24 dispense cycles.
- start with c_type=0, then with c_type=7 -> error pulse one cycle each, busy stays 0, valve stays 0.
- c_type=2, cancel asserted on the 3rd cycle of valve[1] -> valve=0 next edge, aborted=1 one cycle, done never pulses, sel_ing_type returns to 0.
- start pulsed again mid-brew with c_type=3 -> ignored; sel_c_type stays 2; sequence timing unchanged.
- Async reset asserted between clock edges during DISPENSE -> valve=0 and busy=0 before the next clock edge; after release, a fresh start brews normally.
- All t_value=0 -> no valve activity; done after 5×3+1 cycles from start acceptance.

Source files
------------

// File: rtl/brew_sequencer.sv
// Brew controller: latches the coffee type on start, then walks the ingredients in order and
// opens each valve for t_value * UNIT_TICKS cycles. The time-selector supplies t_value.
module brew_sequencer #(
    parameter int unsigned UNIT_TICKS = 50000000,
    parameter int unsigned NUM_ING    = 5,
    parameter int unsigned CNT_W      = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               cancel,
    input  logic [2:0]         c_type,
    input  logic [1:0]         t_value,
    output logic [2:0]         sel_c_type,
    output logic [2:0]         sel_ing_type,
    output logic [NUM_ING-1:0] valve,
    output logic               busy,
    output logic               done,
    output logic               aborted,
    output logic               error
);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] QUERY    = 3'd1;
    localparam logic [2:0] LOAD     = 3'd2;
    localparam logic [2:0] DISPENSE = 3'd3;
    localparam logic [2:0] NEXT     = 3'd4;
    localparam logic [2:0] FINISH   = 3'd5;

    localparam logic [CNT_W-1:0] UNITS    = CNT_W'(UNIT_TICKS);
    localparam logic [2:0]       LAST_ING = 3'(NUM_ING - 1);

    logic [2:0]       state;
    logic [CNT_W-1:0] counter;
    logic             c_type_ok;
    logic             abort_req;

    assign c_type_ok = (c_type != 3'd0) && (c_type <= 3'd4);
    // Cancel is honoured everywhere except IDLE (nothing to abort) and FINISH (done must still pulse).
    assign abort_req = cancel && (state != IDLE) && (state != FINISH);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            sel_c_type   <= '0;
            sel_ing_type <= '0;
            valve        <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            aborted      <= 1'b0;
            error        <= 1'b0;
            counter      <= '0;
        end else begin
            done    <= 1'b0;
            aborted <= 1'b0;
            error   <= 1'b0;
            if (abort_req) begin
                state        <= IDLE;
                valve        <= '0;
                counter      <= '0;
                busy         <= 1'b0;
                aborted      <= 1'b1;
                sel_ing_type <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start && !cancel) begin
                            if (c_type_ok) begin
                                sel_c_type   <= c_type;
                                sel_ing_type <= '0;
                                busy         <= 1'b1;
                                state        <= QUERY;
                            end else begin
                                error <= 1'b1;
                            end
                        end
                    end
                    QUERY: state <= LOAD;
                    LOAD: begin
                        if (t_value == 2'd0) begin
                            state <= NEXT;
                        end else begin
                            counter <= CNT_W'(t_value) * UNITS - CNT_W'(1);
                            valve   <= NUM_ING'(1) << sel_ing_type;
                            state   <= DISPENSE;
                        end
                    end
                    DISPENSE: begin
                        if (counter == '0) begin
                            valve <= '0;
                            state <= NEXT;
                        end else begin
                            counter <= counter - CNT_W'(1);
                        end
                    end
                    NEXT: begin
                        if (sel_ing_type == LAST_ING) begin
                            done  <= 1'b1;
                            state <= FINISH;
                        end else begin
                            sel_ing_type <= sel_ing_type + 3'd1;
                            state        <= QUERY;
                        end
                    end
                    FINISH: begin
                        busy         <= 1'b0;
                        sel_ing_type <= '0;
                        state        <= IDLE;
                    end
                    default: begin
                        valve <= '0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_brew_sequencer.sv
// Scoreboard bench for brew_sequencer: expected valve-open lengths and pulses are queued at
// stimulus time and popped as the monitor observes them.
module tb_brew_sequencer;

    localparam int UNIT = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       cancel = 1'b0;
    logic [2:0] c_type = 3'd0;
    logic [1:0] t_value = 2'd0;
    logic [2:0] sel_c_type;
    logic [2:0] sel_ing_type;
    logic [4:0] valve;
    logic       busy, done, aborted, error;

    always #5 clk = ~clk;

    brew_sequencer #(.UNIT_TICKS(UNIT), .NUM_ING(5), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .start(start), .cancel(cancel), .c_type(c_type),
        .t_value(t_value), .sel_c_type(sel_c_type), .sel_ing_type(sel_ing_type),
        .valve(valve), .busy(busy), .done(done), .aborted(aborted), .error(error)
    );

    // Time-selector model: registered lookup, valid one cycle after the selects change.
    logic [1:0] tv_table [5];
    always @(posedge clk) t_value <= (sel_ing_type < 3'd5) ? tv_table[sel_ing_type] : 2'd0;

    // Event kinds: 0..4 valve i (val = open cycles), 5 done (val = busy cycles before done),
    // 6 aborted, 7 error.
    typedef struct {
        int kind;
        int val;
    } ev_t;
    ev_t sb[$];

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic expect_ev(input int kind, input int val);
        ev_t e;
        e.kind = kind;
        e.val  = val;
        sb.push_back(e);
    endtask

    task automatic emit(input int kind, input int val);
        ev_t e;
        if (sb.size() == 0) begin
            check("unexpected_event", kind, -1);
        end else begin
            e = sb.pop_front();
            check("event_kind", kind, e.kind);
            check("event_value", val, e.val);
        end
    endtask

    int vlen[5] = '{default: 0};
    int busy_run = 0;
    bit prev_done = 1'b0;

    always @(negedge clk) begin
        for (int i = 0; i < 5; i++) begin
            if (valve[i]) vlen[i]++;
            else if (vlen[i] != 0) begin
                emit(i, vlen[i]);
                vlen[i] = 0;
            end
        end
        if (prev_done) check("busy_after_done", int'(busy), 0);
        if (done) emit(5, busy_run);
        if (aborted) emit(6, 0);
        if (error) emit(7, 0);
        if (busy && !done) busy_run++;
        else if (!busy) busy_run = 0;
        prev_done = done;
        check("valve_onehot", int'($onehot0(valve)), 1);
        check("pulse_exclusive", int'($onehot0({done, aborted, error})), 1);
    end

    task automatic do_start(input logic [2:0] ct);
        start  = 1'b1;
        c_type = ct;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_valve(input int idx, input int n);
        int cnt;
        cnt = 0;
        for (int i = 0; i < 300 && cnt < n; i++) begin
            @(negedge clk);
            if (valve[idx]) cnt++;
        end
        check("valve_wait", cnt, n);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 400; i++) begin
            if (sb.size() == 0 && !busy) break;
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
        check("scoreboard_drain", sb.size(), 0);
        check("idle_busy", int'(busy), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected finish before timeout");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tv_table = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
        #1 reset = 1'b1;
        #2 check("reset_state", int'({sel_c_type, sel_ing_type, valve, busy, done, aborted, error}), 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Full brew, c_type 1, times {2,3,0,0,1}
        tv_table = '{2'd2, 2'd3, 2'd0, 2'd0, 2'd1};
        expect_ev(0, 2 * UNIT);
        expect_ev(1, 3 * UNIT);
        expect_ev(4, 1 * UNIT);
        expect_ev(5, 15 + 6 * UNIT);
        do_start(3'd1);
        check("busy_on_start", int'(busy), 1);
        check("sel_c_type_latched", int'(sel_c_type), 1);
        check("sel_ing_start", int'(sel_ing_type), 0);
        wait_drain();
        check("sel_ing_after_done", int'(sel_ing_type), 0);
        check("sel_c_type_holds", int'(sel_c_type), 1);

        // Invalid coffee types
        expect_ev(7, 0);
        do_start(3'd0);
        check("err0_busy", int'(busy), 0);
        check("err0_valve", int'(valve), 0);
        expect_ev(7, 0);
        do_start(3'd7);
        check("err7_busy", int'(busy), 0);
        wait_drain();

        // Start together with cancel is ignored
        cancel = 1'b1;
        do_start(3'd1);
        cancel = 1'b0;
        check("start_cancel_busy", int'(busy), 0);
        wait_drain();

        // Mid-brew start with another type is ignored
        tv_table = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd1};
        for (int i = 0; i < 5; i++) expect_ev(i, UNIT);
        expect_ev(5, 15 + 5 * UNIT);
        do_start(3'd2);
        wait_valve(0, 1);
        start  = 1'b1;
        c_type = 3'd3;
        @(negedge clk);
        start = 1'b0;
        check("midstart_sel_c_type", int'(sel_c_type), 2);
        wait_drain();

        // Cancel on the 3rd cycle of valve[1]
        tv_table = '{2'd1, 2'd3, 2'd2, 2'd1, 2'd1};
        expect_ev(0, UNIT);
        expect_ev(1, 3);
        expect_ev(6, 0);
        do_start(3'd2);
        wait_valve(1, 3);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        check("cancel_valve", int'(valve), 0);
        check("cancel_busy", int'(busy), 0);
        check("cancel_sel_ing", int'(sel_ing_type), 0);
        wait_drain();

        // Async reset during dispense, then a fresh brew
        tv_table = '{2'd2, 2'd3, 2'd0, 2'd0, 2'd1};
        expect_ev(0, 3);
        do_start(3'd1);
        wait_valve(0, 3);
        #2 reset = 1'b1;
        #1 check("async_reset_valve", int'(valve), 0);
        check("async_reset_busy", int'(busy), 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        tv_table = '{2'd1, 2'd0, 2'd0, 2'd0, 2'd2};
        expect_ev(0, UNIT);
        expect_ev(4, 2 * UNIT);
        expect_ev(5, 15 + 3 * UNIT);
        do_start(3'd4);
        check("restart_sel_c_type", int'(sel_c_type), 4);
        wait_drain();

        // All-zero times: no valve activity, done after 5*3+1 cycles
        tv_table = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
        expect_ev(5, 15);
        do_start(3'd3);
        wait_drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
